// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - 4-bit operation codes driven on mdu_seq.op
//   - sequencer state and commit-mode encodings
//   - is_long_op(): true for operations that occupy the unit for several cycles
// Optional feature macro: MDU_MADD_EN (multiply-accumulate/subtract ops).
package mdu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] NOP   = 4'd0;
    localparam logic [OP_W-1:0] MULT  = 4'd1;
    localparam logic [OP_W-1:0] MULTU = 4'd2;
    localparam logic [OP_W-1:0] DIV   = 4'd3;
    localparam logic [OP_W-1:0] DIVU  = 4'd4;
    localparam logic [OP_W-1:0] MFHI  = 4'd5;
    localparam logic [OP_W-1:0] MFLO  = 4'd6;
    localparam logic [OP_W-1:0] MTHI  = 4'd7;
    localparam logic [OP_W-1:0] MTLO  = 4'd8;
    localparam logic [OP_W-1:0] MADD  = 4'd9;
    localparam logic [OP_W-1:0] MADDU = 4'd10;
    localparam logic [OP_W-1:0] MSUB  = 4'd11;
    localparam logic [OP_W-1:0] MSUBU = 4'd12;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // What the pending product/quotient does to {hi,lo} when the busy period ends.
    typedef enum logic [1:0] {
        CMT_KEEP = 2'd0,
        CMT_SET  = 2'd1,
        CMT_ADD  = 2'd2,
        CMT_SUB  = 2'd3
    } commit_e;

    function automatic logic is_long_op(input logic [OP_W-1:0] op);
        logic long_op;
        long_op = (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
`ifdef MDU_MADD_EN
        long_op = long_op || (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
`endif
        return long_op;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: combinational signed/unsigned divider.
//   a, b       : dividend / divisor
//   is_signed  : 1 = div (truncate toward zero, remainder takes dividend sign), 0 = divu
//   quot, rem  : quotient / remainder (don't-care when div_zero)
//   div_zero   : divisor is zero; the sequencer leaves hi/lo untouched
module mdu_div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;

    // Divide magnitudes, then restore signs.
    always_comb begin
        a_neg    = is_signed & a[WIDTH-1];
        b_neg    = is_signed & b[WIDTH-1];
        a_mag    = a_neg ? (-a) : a;
        b_mag    = b_neg ? (-b) : b;
        div_zero = (b == '0);
        // Keep the divider away from a zero divisor; the result is discarded anyway.
        divisor  = div_zero ? WIDTH'(1) : b_mag;
        q_mag    = a_mag / divisor;
        r_mag    = a_mag % divisor;
        quot     = (a_neg ^ b_neg) ? (-q_mag) : q_mag;
        rem      = a_neg ? (-r_mag) : r_mag;
        // most-negative / -1 wraps back to most-negative with a zero remainder.
        if (is_signed && (a == MOST_NEG) && (b == '1)) begin
            quot = MOST_NEG;
            rem  = '0;
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: E-stage multiply/divide unit owning the HI/LO registers.
//   clk, reset     : rising-edge clock, async active-high reset
//   op, start      : operation code, qualified by start
//   cancel         : flush of the E-stage instruction; blocks acceptance
//   a, b           : forwarded rs/rt operands
//   busy           : long operation in flight (hazard unit stalls on it)
//   hi, lo         : architectural HI/LO
//   out            : combinational mfhi/mflo read data, zero for other ops
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] out
);

    localparam int unsigned PW      = 2 * WIDTH;
    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_e           state_q, state_d;
    commit_e          mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [PW-1:0]    pend_q, pend_d;

    logic             accept;
    logic             div_signed;
    logic             is_div;
    logic [PW-1:0]    prod_s;
    logic [PW-1:0]    prod_u;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             div_zero;

    // Full-width products; sign extension makes the truncated product exact for signed operands.
    always_comb begin
        prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end

    assign div_signed = (op == DIV);
    assign is_div     = (op == DIV) || (op == DIVU);

    mdu_div_core #(
        .WIDTH(WIDTH)
    ) u_div (
        .a        (a),
        .b        (b),
        .is_signed(div_signed),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero)
    );

    assign accept = start & ~cancel & (state_q == IDLE);

    // Next-state: accept in IDLE, count down in BUSY, commit on the last busy cycle.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_long_op(op)) begin
                        state_d = BUSY;
                        cnt_d   = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                    end
                    case (op)
                        MULT: begin
                            pend_d = prod_s;
                            mode_d = CMT_SET;
                        end
                        MULTU: begin
                            pend_d = prod_u;
                            mode_d = CMT_SET;
                        end
                        DIV, DIVU: begin
                            pend_d = {rem, quot};
                            mode_d = div_zero ? CMT_KEEP : CMT_SET;
                        end
                        MTHI: hi_d = a;
                        MTLO: lo_d = a;
`ifdef MDU_MADD_EN
                        MADD: begin
                            pend_d = prod_s;
                            mode_d = CMT_ADD;
                        end
                        MADDU: begin
                            pend_d = prod_u;
                            mode_d = CMT_ADD;
                        end
                        MSUB: begin
                            pend_d = prod_s;
                            mode_d = CMT_SUB;
                        end
                        MSUBU: begin
                            pend_d = prod_u;
                            mode_d = CMT_SUB;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    case (mode_q)
                        CMT_SET: {hi_d, lo_d} = pend_q;
                        CMT_ADD: {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
                        CMT_SUB: {hi_d, lo_d} = {hi_q, lo_q} - pend_q;
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= CMT_KEEP;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end

    // mfhi/mflo read port.
    always_comb begin
        out = '0;
        if (op == MFHI) begin
            out = hi_q;
        end else if (op == MFLO) begin
            out = lo_q;
        end
    end

    assign busy = (state_q == BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: scoreboard bench for mdu_seq (default 32-bit build plus a 16-bit,
// single-cycle-multiply instance).
module tb_mdu_seq;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic        start, cancel;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo, out;

    logic [3:0]  op2;
    logic        start2, cancel2;
    logic [15:0] a2, b2;
    logic        busy2;
    logic [15:0] hi2, lo2, out2;

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .op(op), .start(start), .cancel(cancel),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo), .out(out)
    );

    mdu_seq #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
        .clk(clk), .reset(reset), .op(op2), .start(start2), .cancel(cancel2),
        .a(a2), .b(b2), .busy(busy2), .hi(hi2), .lo(lo2), .out(out2)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state.
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    int          m_left;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: a falling busy marks a completed long operation.
    int mon_cnt  = 0;
    bit mon_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            mon_cnt  = 0;
            mon_prev = 1'b0;
        end else if (busy) begin
            mon_cnt++;
            mon_prev = 1'b1;
        end else if (mon_prev) begin
            chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_busy_len", 64'(mon_cnt), 64'(e.cycles));
                chk("sb_hi", hi, e.hi);
                chk("sb_lo", lo, e.lo);
            end
            mon_cnt  = 0;
            mon_prev = 1'b0;
        end
    end

    task automatic model_accept(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] res, ux, uy;
        int          n;
        bit          long_op;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        res = {m_hi, m_lo};
        n = 0;
        long_op = 1'b1;
        case (o)
            MULT:  begin res = 64'(sx * sy); n = MC; end
            MULTU: begin res = ux * uy; n = MC; end
            DIV: begin
                n = DC;
                if (y != 0) begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            DIVU: begin
                n = DC;
                if (y != 0) res = {(ux % uy) & 64'hFFFF_FFFF, 32'h0} | ((ux / uy) & 64'hFFFF_FFFF);
            end
            MTHI: begin m_hi = x; long_op = 1'b0; end
            MTLO: begin m_lo = x; long_op = 1'b0; end
            default: long_op = 1'b0;
        endcase
        if (long_op) begin
            m_pend = res;
            m_left = n;
            sb_q.push_back('{res[63:32], res[31:0], n});
        end
    endtask

    // One clock cycle of stimulus on the 32-bit unit; entered and left at posedge+1.
    task automatic step(input logic [3:0] o, input logic s, input logic c,
                        input logic [31:0] x, input logic [31:0] y);
        logic [31:0] exp_out;
        op = o; start = s; cancel = c; a = x; b = y;
        #1;
        exp_out = (o == MFHI) ? m_hi : (o == MFLO) ? m_lo : 32'h0;
        chk("out", out, exp_out);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) {m_hi, m_lo} = m_pend;
        end else if (s && !c) begin
            model_accept(o, x, y);
        end
        @(posedge clk); #1;
        chk("busy", busy, 64'(m_left > 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(NOP, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        op = NOP; start = 0; cancel = 0; a = 0; b = 0;
        op2 = NOP; start2 = 0; cancel2 = 0; a2 = 0; b2 = 0;
        m_hi = 0; m_lo = 0; m_pend = 0; m_left = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_hi16", hi2, 0);
        reset = 1'b0;

        // mult -3 * 7
        step(MULT, 1, 0, 32'hFFFF_FFFD, 32'd7);
        idle(6);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);

        // div -7 / 2
        step(DIV, 1, 0, 32'hFFFF_FFF9, 32'd2);
        idle(11);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // divu by zero keeps hi/lo
        step(MTHI, 1, 0, 32'd1, 32'd0);
        step(MTLO, 1, 0, 32'd2, 32'd0);
        step(DIVU, 1, 0, 32'd100, 32'd0);
        idle(11);
        chk("divz_hi", hi, 32'd1);
        chk("divz_lo", lo, 32'd2);

        // start during busy is ignored
        step(MULT, 1, 0, 32'd1000, 32'd3000);
        step(MTHI, 1, 0, 32'd5, 32'd0);
        step(MULT, 1, 0, 32'd7, 32'd9);
        idle(5);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd3_000_000);

        // cancel blocks mtlo
        step(MTLO, 1, 1, 32'h1234, 32'd0);
        chk("cancel_lo", lo, 32'd3_000_000);
        step(MTLO, 1, 0, 32'h1234, 32'd0);
        chk("mtlo_lo", lo, 32'h1234);
        op = MFLO; start = 0;
        #1;
        chk("mflo_out", out, 32'h1234);

        // most-negative / -1
        step(DIV, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(11);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'h0);

        // signed divide by zero
        step(DIV, 1, 0, 32'd5, 32'd0);
        idle(11);

        // reset in the third cycle of a divu
        step(MTLO, 1, 0, 32'h55, 32'd0);
        step(DIVU, 1, 0, 32'd1000, 32'd7);
        idle(2);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_hi", hi, 0);
        chk("mid_rst_lo", lo, 0);
        sb_q.delete();
        m_hi = 0; m_lo = 0; m_pend = 0; m_left = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(12);
        chk("post_rst_lo", lo, 0);

        // randomized mix
        for (int i = 0; i < 300; i++) begin
            logic [3:0] ro;
            ro = 4'($urandom_range(0, 15));
            step(ro, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), pick(), pick());
        end
        idle(12);
        chk("sb_drain", 64'(sb_q.size()), 0);

        // 16-bit, single-cycle multiply instance
        op2 = MULTU; start2 = 1; a2 = 16'hFFFF; b2 = 16'hFFFF;
        @(posedge clk); #1;
        start2 = 0; op2 = NOP;
        chk("w16_busy1", busy2, 1);
        @(posedge clk); #1;
        chk("w16_busy0", busy2, 0);
        chk("w16_hi", hi2, 16'hFFFE);
        chk("w16_lo", lo2, 16'h0001);
        for (int i = 0; i < 6; i++) begin
            logic [15:0] x16, y16;
            int          p;
            x16 = 16'($urandom);
            y16 = 16'($urandom);
            p = int'($signed(x16)) * int'($signed(y16));
            op2 = MULT; start2 = 1; a2 = x16; b2 = y16;
            @(posedge clk); #1;
            start2 = 0; op2 = NOP; a2 = 16'h0; b2 = 16'h0;
            @(posedge clk); #1;
            chk("w16_mult_hi", hi2, 64'(p[31:16]));
            chk("w16_mult_lo", lo2, 64'(p[15:0]));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
